// File: rtl/alu_control_md.sv
// ALU control decode plus an iterative multiply/divide engine that owns the HI/LO registers.
// A request runs IDLE -> CALC (WIDTH iterations) -> FIN, and HI/LO are written on the edge leaving FIN.
module alu_control_md #(
  parameter int WIDTH   = 32,
  parameter int ALUOP_W = 4,
  parameter int CONF_W  = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ALUOP_W-1:0] ALUOp,
  input  logic [5:0]         Funct,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [CONF_W-1:0]  ALUConf,
  output logic               Sign,
  output logic               md_op,
  output logic               busy,
  output logic               done,
  output logic               div_zero,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;

  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_dz_pend;
  logic [WIDTH-1:0]   r_x;
  logic [2*WIDTH-1:0] r_p;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic               r_div_zero;

  logic [CONF_W-1:0]  w_conf;
  logic               w_sign;
  logic               w_rtype;
  logic               w_signed;
  logic               w_is_div;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_rem_sh;
  logic               w_ge;
  logic [WIDTH-1:0]   w_diff;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  always_comb begin
    w_conf = '0;
    w_sign = 1'b0;
    case (ALUOp)
      ALUOP_W'(4'h4): w_sign = 1'b1;
      ALUOP_W'(4'h5): begin w_conf = CONF_W'(9); w_sign = 1'b1; end
      ALUOP_W'(4'h1): w_conf = CONF_W'(9);
      ALUOP_W'(4'h2): w_conf = CONF_W'(2);
      ALUOP_W'(4'h6): w_conf = CONF_W'(1);
      ALUOP_W'(4'h3): begin
        case (Funct)
          6'h20:   w_sign = 1'b1;
          6'h22:   begin w_conf = CONF_W'(1); w_sign = 1'b1; end
          6'h23:   w_conf = CONF_W'(1);
          6'h24:   begin w_conf = CONF_W'(2); w_sign = 1'b1; end
          6'h25:   begin w_conf = CONF_W'(3); w_sign = 1'b1; end
          6'h26:   begin w_conf = CONF_W'(4); w_sign = 1'b1; end
          6'h27:   begin w_conf = CONF_W'(5); w_sign = 1'b1; end
          6'h00:   w_conf = CONF_W'(6);
          6'h02:   w_conf = CONF_W'(7);
          6'h03:   begin w_conf = CONF_W'(8); w_sign = 1'b1; end
          6'h2a:   begin w_conf = CONF_W'(9); w_sign = 1'b1; end
          6'h2b:   w_conf = CONF_W'(9);
          F_MULT, F_DIV: w_sign = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign ALUConf = w_conf;
  assign Sign    = w_sign;
  assign w_rtype = (ALUOp == ALUOP_W'(4'h3));
  assign md_op   = w_rtype && (Funct == F_MULT || Funct == F_MULTU ||
                               Funct == F_DIV  || Funct == F_DIVU);

  // The engine works on magnitudes only; signs are reapplied in FIN.
  assign w_signed = (Funct == F_MULT) || (Funct == F_DIV);
  assign w_is_div = (Funct == F_DIV)  || (Funct == F_DIVU);
  assign w_a_mag  = (w_signed && a[WIDTH-1]) ? -a : a;
  assign w_b_mag  = (w_signed && b[WIDTH-1]) ? -b : b;

  // Multiply: the low half of r_p starts as the multiplier and drains out as product bits enter.
  assign w_mul_sum  = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_x} : '0);
  assign w_mul_next = {w_mul_sum, r_p[WIDTH-1:1]};

  // Divide: r_p = {remainder, dividend/quotient}; quotient bits shift in from the right.
  assign w_rem_sh   = {r_p[2*WIDTH-1:WIDTH], r_p[WIDTH-1]};
  assign w_ge       = (w_rem_sh >= {1'b0, r_x});
  assign w_diff     = w_rem_sh[WIDTH-1:0] - r_x;
  assign w_div_next = w_ge ? {w_diff, r_p[WIDTH-2:0], 1'b1}
                           : {w_rem_sh[WIDTH-1:0], r_p[WIDTH-2:0], 1'b0};

  assign w_prod_fix = r_neg_q ? -r_p : r_p;
  assign w_quo_fix  = r_neg_q ? -r_p[WIDTH-1:0] : r_p[WIDTH-1:0];
  assign w_rem_fix  = r_neg_r ? -r_p[2*WIDTH-1:WIDTH] : r_p[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_is_div   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_dz_pend  <= 1'b0;
      r_x        <= '0;
      r_p        <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && w_rtype) begin
            case (Funct)
              F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                r_is_div  <= w_is_div;
                r_neg_q   <= w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                r_neg_r   <= w_signed & a[WIDTH-1];
                r_x       <= w_is_div ? w_b_mag : w_a_mag;
                r_p       <= {{WIDTH{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
                r_cnt     <= '0;
                r_dz_pend <= w_is_div && (b == '0);
                r_state   <= (w_is_div && (b == '0)) ? S_FIN : S_CALC;
              end
              F_MTHI:  r_hi <= a;
              F_MTLO:  r_lo <= a;
              default: ;
            endcase
          end
        end
        S_CALC: begin
          r_p <= r_is_div ? w_div_next : w_mul_next;
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_state <= S_FIN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_FIN: begin
          r_done     <= 1'b1;
          r_div_zero <= r_dz_pend;
          if (!r_dz_pend) begin
            if (r_is_div) begin
              r_hi <= w_rem_fix;
              r_lo <= w_quo_fix;
            end else begin
              r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
              r_lo <= w_prod_fix[WIDTH-1:0];
            end
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy     = (r_state == S_CALC);
  assign done     = r_done;
  assign div_zero = r_div_zero;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule
